usr_shift_ctrl: RTL and testbench
=================================

Name: usr_shift_ctrl

Overview:
- Command sequencer for the 4-bit universal shift register datapath.
- Accepts load/shift commands over a valid/ready handshake.
- Drives the register's 2-bit mode select, serial-in bits and parallel-load word cycle by cycle, then pulses done.
- Sits between the system-level control logic and the register/mux slice; it owns the mode select lines exclusively.

Parameters:
WIDTH, 4, register width; width of cmd_data and par_out.
CNT_W, 3, shift-count width; max shifts per command = 2^CNT_W-1.

Ports:
clk  input  1  clock, rising edge.
rst  input  1  synchronous, active-high reset.
cmd_valid  input  1  command present.
cmd_ready  output  1  controller can accept a command (IDLE only).
cmd_op  input  2  01 shift right, 10 shift left, 11 parallel load, 00 no-op.
cmd_count  input  CNT_W  number of shift cycles; ignored for load/no-op.
cmd_sin  input  1  serial fill bit for shifts.
cmd_data  input  WIDTH  parallel load word.
abort  input  1  terminate the active command early.
q  input  WIDTH  current register contents; used only with rotate feature.
mode_sel  output  2  to register muxes: 00 hold, 01 shift right, 10 shift left, 11 load.
ser_in_r  output  1  serial input for shift right (enters MSB).
ser_in_l  output  1  serial input for shift left (enters LSB).
par_out  output  WIDTH  parallel load word to register.
busy  output  1  high in RUN and DONE.
done  output  1  one-cycle completion pulse.
aborted  output  1  qualifies done; high when the command ended via abort.

Behaviour:
- All outputs are registered.
- Reset values: mode_sel=00, ser_in_r=0, ser_in_l=0, par_out=0, busy=0, done=0, aborted=0, cmd_ready=1. State resets to IDLE.
- A reset asserted mid-command abandons the command: next cycle is IDLE with hold mode and no done pulse.
- FSM IDLE:
  - cmd_ready=1, mode_sel=00.
  - Accept when cmd_valid&cmd_ready at a rising edge; latch op, count, sin and data.
  - op 11 -> RUN with cnt=1.
  - op 01/10 with count>0 -> RUN with cnt=count.
  - op 01/10 with count=0, or op 00 -> DONE directly; mode_sel stays 00.
- FSM RUN:
  - mode_sel=latched op. ser_in_r=sin on shift right, ser_in_l=sin on shift left; the unused serial input is 0. par_out=latched data during load.
  - cnt decrements each cycle.
  - When cnt=1, go to DONE next edge. Exactly N cycles with the shift mode, or 1 cycle with load mode.
- FSM DONE:
  - mode_sel=00, done=1 for one cycle, busy=1, cmd_ready=0.
  - Next state is IDLE.
- Latency: command accepted at edge T. Mode active on cycles T+1..T+N. done high in cycle T+N+1. cmd_ready returns in cycle T+N+2.
- Back-to-back commands: minimum spacing is N+2 cycles.
- abort:
  - Sampled only in RUN. Forces DONE at the next edge with aborted=1 alongside done.
  - The shift cycle in which abort is sampled is still applied; mode_sel drops to 00 the following cycle.
  - abort in IDLE or DONE is ignored.
- Simultaneous cmd_valid and abort in IDLE: the command is accepted and abort is ignored.
- cmd_* inputs are don't-care outside the accept edge; the command is latched on acceptance.
- The counter never wraps. Count is bounded by CNT_W, and count=0 is handled as above.

Optional Feature:
USR_ROTATE_EN
- Defined: cmd_sin=1 together with shift op selects rotate instead of fill. Each RUN cycle sets ser_in_r=q[0] (right) or ser_in_l=q[WIDTH-1] (left), giving circular shift.
- Not defined: q is unused, and cmd_sin is always the literal fill bit.
- All other timing is identical in both builds.

Test Plan:
1. rst held 2 cycles mid-RUN of a 5-shift command -> next cycle IDLE, mode_sel=00, cmd_ready=1, no done pulse.
2. Load cmd_data=4'b1011 accepted at T -> mode_sel=11 and par_out=1011 in T+1 only; done=1 at T+2; cmd_ready=1 at T+3.
3. Shift right, count=3, sin=1 -> mode_sel=01 and ser_in_r=1 for exactly 3 cycles, then done. Register preloaded 0000 ends at 1110.
4. Shift left, count=0 -> mode_sel stays 00; done=1 one cycle after accept, aborted=0.
5. Shift left, count=7; abort at the 3rd RUN cycle -> 3 cycles of mode_sel=10; next cycle done=1 and aborted=1; then IDLE.
6. With USR_ROTATE_EN: q=1001, rotate right count=1 -> ser_in_r=1 during RUN; register becomes 1100. Without the macro the same command fills with 1, giving 1100 here too. Repeat with q=1000: rotate yields 0100, fill yields 1100.

Source files
------------

// File: rtl/usr_shift_ctrl.sv
// Command sequencer for the universal shift register: drives mode select, serial-in and load word.
// Optional build macro USR_ROTATE_EN: cmd_sin=1 on a shift op selects circular rotate via q.
module usr_shift_ctrl #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [CNT_W-1:0] cmd_count,
    input  logic             cmd_sin,
    input  logic [WIDTH-1:0] cmd_data,
    input  logic             abort,
    input  logic [WIDTH-1:0] q,
    output logic [1:0]       mode_sel,
    output logic             ser_in_r,
    output logic             ser_in_l,
    output logic [WIDTH-1:0] par_out,
    output logic             busy,
    output logic             done,
    output logic             aborted
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [1:0] OP_NOP = 2'b00;
    localparam logic [1:0] OP_SHR = 2'b01;
    localparam logic [1:0] OP_SHL = 2'b10;
    localparam logic [1:0] OP_LD  = 2'b11;

    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic             first_r;
    logic             first_l;

`ifdef USR_ROTATE_EN
    logic rot;

    // Rotate feeds back the bit that is about to leave the register; with sin=0 it is a 0-fill.
    assign first_r = cmd_sin & q[0];
    assign first_l = cmd_sin & q[WIDTH-1];
`else
    logic unused_q;

    assign unused_q = ^q;
    assign first_r  = cmd_sin;
    assign first_l  = cmd_sin;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            cmd_ready <= 1'b1;
            mode_sel  <= OP_NOP;
            ser_in_r  <= 1'b0;
            ser_in_l  <= 1'b0;
            par_out   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            aborted   <= 1'b0;
`ifdef USR_ROTATE_EN
            rot       <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        cmd_ready <= 1'b0;
                        busy      <= 1'b1;
                        if (cmd_op == OP_LD) begin
                            state    <= RUN;
                            cnt      <= CNT_W'(1);
                            mode_sel <= OP_LD;
                            par_out  <= cmd_data;
                        end else if (cmd_op != OP_NOP && cmd_count != '0) begin
                            state    <= RUN;
                            cnt      <= cmd_count;
                            mode_sel <= cmd_op;
                            ser_in_r <= (cmd_op == OP_SHR) ? first_r : 1'b0;
                            ser_in_l <= (cmd_op == OP_SHL) ? first_l : 1'b0;
`ifdef USR_ROTATE_EN
                            rot      <= cmd_sin;
`endif
                        end else begin
                            state <= DONE;
                            done  <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    cnt <= cnt - 1'b1;
                    if (abort || cnt == CNT_W'(1)) begin
                        state    <= DONE;
                        mode_sel <= OP_NOP;
                        ser_in_r <= 1'b0;
                        ser_in_l <= 1'b0;
                        par_out  <= '0;
                        done     <= 1'b1;
                        aborted  <= abort;
                    end else begin
`ifdef USR_ROTATE_EN
                        // Registered output: predict the post-shift end bit, since q moves on this same edge.
                        if (rot && mode_sel == OP_SHR) ser_in_r <= q[1];
                        if (rot && mode_sel == OP_SHL) ser_in_l <= q[WIDTH-2];
`endif
                    end
                end
                DONE: begin
                    state     <= IDLE;
                    done      <= 1'b0;
                    aborted   <= 1'b0;
                    busy      <= 1'b0;
                    cmd_ready <= 1'b1;
                end
                default: begin
                    state     <= IDLE;
                    mode_sel  <= OP_NOP;
                    ser_in_r  <= 1'b0;
                    ser_in_l  <= 1'b0;
                    par_out   <= '0;
                    done      <= 1'b0;
                    aborted   <= 1'b0;
                    busy      <= 1'b0;
                    cmd_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_usr_shift_ctrl.sv
// Self-checking bench for usr_shift_ctrl with a behavioural 4-bit register closing the q loop.
module tb_usr_shift_ctrl;

    localparam int WIDTH = 4;
    localparam int CNT_W = 3;

    logic             clk = 1'b0;
    logic             rst;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_op;
    logic [CNT_W-1:0] cmd_count;
    logic             cmd_sin;
    logic [WIDTH-1:0] cmd_data;
    logic             abort;
    logic [WIDTH-1:0] q;
    logic [1:0]       mode_sel;
    logic             ser_in_r;
    logic             ser_in_l;
    logic [WIDTH-1:0] par_out;
    logic             busy;
    logic             done;
    logic             aborted;

    logic [WIDTH-1:0] reg_q;
    logic             pre_load;
    logic [WIDTH-1:0] pre_val;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    usr_shift_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_count(cmd_count), .cmd_sin(cmd_sin), .cmd_data(cmd_data),
        .abort(abort), .q(q),
        .mode_sel(mode_sel), .ser_in_r(ser_in_r), .ser_in_l(ser_in_l), .par_out(par_out),
        .busy(busy), .done(done), .aborted(aborted)
    );

    // The register/mux slice the controller drives.
    always_ff @(posedge clk) begin
        if (pre_load) reg_q <= pre_val;
        else begin
            case (mode_sel)
                2'b01:   reg_q <= {ser_in_r, reg_q[WIDTH-1:1]};
                2'b10:   reg_q <= {reg_q[WIDTH-2:0], ser_in_l};
                2'b11:   reg_q <= par_out;
                default: reg_q <= reg_q;
            endcase
        end
    end
    assign q = reg_q;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string tag);
        check_eq({tag, "_ready"}, 32'(cmd_ready), 32'd1);
        check_eq({tag, "_mode"},  32'(mode_sel),  32'd0);
        check_eq({tag, "_busy"},  32'(busy),      32'd0);
        check_eq({tag, "_done"},  32'(done),      32'd0);
        check_eq({tag, "_abtd"},  32'(aborted),   32'd0);
    endtask

    // Reference: a command yields N mode cycles (1 for load, 0 for no-op/zero count),
    // cut short at the RUN cycle where abort is raised, then one done cycle.
    task automatic run_cmd(input logic [1:0] op, input int count, input logic sin,
                           input logic [WIDTH-1:0] data, input int abort_at,
                           input logic [WIDTH-1:0] pre);
        int n;
        int runs;
        logic ab;
        logic b;
        logic [WIDTH-1:0] mq;
        pre_load = 1'b1;
        pre_val  = pre;
        step();
        pre_load = 1'b0;
        check_idle("pre");
        mq   = pre;
        n    = (op == 2'b11) ? 1 : ((op != 2'b00 && count > 0) ? count : 0);
        ab   = (abort_at > 0 && abort_at <= n);
        runs = ab ? abort_at : n;
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_count = count[CNT_W-1:0];
        cmd_sin   = sin;
        cmd_data  = data;
        abort     = 1'($urandom);
        step();
        cmd_valid = 1'b0;
        cmd_op    = 2'($urandom);
        cmd_count = 3'($urandom);
        cmd_sin   = 1'($urandom);
        cmd_data  = 4'($urandom);
        for (int k = 1; k <= runs; k++) begin
            abort = ab && (k == runs);
            check_eq("run_mode",  32'(mode_sel),  32'(op));
            check_eq("run_busy",  32'(busy),      32'd1);
            check_eq("run_done",  32'(done),      32'd0);
            check_eq("run_ready", 32'(cmd_ready), 32'd0);
            if (op == 2'b11) begin
                check_eq("run_par", 32'(par_out), 32'(data));
                mq = data;
            end else begin
                b = sin;
`ifdef USR_ROTATE_EN
                if (sin) b = (op == 2'b01) ? mq[0] : mq[WIDTH-1];
`endif
                if (op == 2'b01) begin
                    check_eq("run_sr", 32'(ser_in_r), 32'(b));
                    check_eq("run_sl", 32'(ser_in_l), 32'd0);
                    mq = (mq >> 1) | ({3'b000, b} << 3);
                end else begin
                    check_eq("run_sl", 32'(ser_in_l), 32'(b));
                    check_eq("run_sr", 32'(ser_in_r), 32'd0);
                    mq = (mq << 1) | {3'b000, b};
                end
            end
            step();
        end
        abort = 1'($urandom);
        check_eq("done_pulse", 32'(done),      32'd1);
        check_eq("done_abtd",  32'(aborted),   32'(ab));
        check_eq("done_mode",  32'(mode_sel),  32'd0);
        check_eq("done_busy",  32'(busy),      32'd1);
        check_eq("done_ready", 32'(cmd_ready), 32'd0);
        check_eq("reg_result", 32'(reg_q),     32'(mq));
        step();
        abort = 1'b0;
        check_idle("post");
    endtask

    initial begin
        rst = 1'b1; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_count = '0;
        cmd_sin = 1'b0; cmd_data = '0; abort = 1'b0; pre_load = 1'b0; pre_val = '0;
        step();
        step();
        check_idle("rst");
        check_eq("rst_sr",  32'(ser_in_r), 32'd0);
        check_eq("rst_sl",  32'(ser_in_l), 32'd0);
        check_eq("rst_par", 32'(par_out),  32'd0);
        rst = 1'b0;
        step();
        check_idle("rst_rel");

        // Reset mid-RUN of a 5-shift command.
        cmd_valid = 1'b1; cmd_op = 2'b01; cmd_count = 3'd5; cmd_sin = 1'b1;
        step();
        cmd_valid = 1'b0;
        step();
        check_eq("mid_mode", 32'(mode_sel), 32'd1);
        rst = 1'b1;
        step();
        check_eq("mid_rst_done", 32'(done), 32'd0);
        step();
        check_eq("mid_rst_done2", 32'(done), 32'd0);
        rst = 1'b0;
        check_idle("mid_rst");
        step();
        check_idle("mid_after");

        // abort alone in IDLE is ignored.
        abort = 1'b1;
        step();
        step();
        abort = 1'b0;
        check_idle("idle_abort");

        run_cmd(2'b11, 0, 1'b0, 4'b1011, 0, 4'b0000);
        check_eq("load_final", 32'(reg_q), 32'hb);
        run_cmd(2'b01, 3, 1'b1, 4'b0000, 0, 4'b0000);
        check_eq("shr3_final", 32'(reg_q), 32'he);
        run_cmd(2'b10, 0, 1'b1, 4'b0000, 0, 4'b0101);
        run_cmd(2'b10, 7, 1'b0, 4'b0000, 3, 4'b1111);
        check_eq("abort_final", 32'(reg_q), 32'h8);
        run_cmd(2'b00, 5, 1'b1, 4'b1111, 0, 4'b0011);
        run_cmd(2'b01, 1, 1'b1, 4'b0000, 0, 4'b1001);
        check_eq("rot_1001", 32'(reg_q), 32'hc);
        run_cmd(2'b01, 1, 1'b1, 4'b0000, 0, 4'b1000);
`ifdef USR_ROTATE_EN
        check_eq("rot_1000", 32'(reg_q), 32'h4);
`else
        check_eq("fill_1000", 32'(reg_q), 32'hc);
`endif

        for (int i = 0; i < 60; i++) begin
            run_cmd(2'($urandom), int'($urandom_range(0, 7)), 1'($urandom), 4'($urandom),
                    ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 7)) : 0,
                    4'($urandom));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
